hazard_scoreboard_unit: RTL

Parametrised next-generation hazard unit for the 5-stage RISC-V pipeline. It keeps the load-use stall and EX/MEM and MEM/WB forwarding. It adds a registered per-register busy scoreboard for variable-latency operations (mul/div, multi-cycle memory), which drives RAW and WAW stalls and bounds the number of outstanding long operations. It also forwards directly from the long-op completion port and keeps a saturating stall-cycle counter. It sits beside the ID stage and drives the PC/IF_ID hold and the operand-mux selects.

---
 rtl/hazard_scoreboard_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage RISC-V pipeline: load-use stall, EX/MEM, MEM/WB
// and long-op completion forwarding, plus a per-register busy scoreboard for
// variable-latency operations with RAW/WAW/capacity stalls.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MAX_LONG   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            id_valid,
  input  logic [REG_ADDR_W-1:0]           id_rs1,
  input  logic [REG_ADDR_W-1:0]           id_rs2,
  input  logic                            id_rs1_used,
  input  logic                            id_rs2_used,
  input  logic [REG_ADDR_W-1:0]           id_rd,
  input  logic                            id_reg_write,
  input  logic                            id_long_op,
  input  logic                            flush,
  input  logic                            ex_valid,
  input  logic                            ex_mem_read,
  input  logic [REG_ADDR_W-1:0]           ex_rd,
  input  logic                            mem_reg_write,
  input  logic [REG_ADDR_W-1:0]           mem_rd,
  input  logic                            wb_reg_write,
  input  logic [REG_ADDR_W-1:0]           wb_rd,
  input  logic                            lc_done,
  input  logic [REG_ADDR_W-1:0]           lc_rd,
  output logic                            stall,
  output logic [1:0]                      forward_a,
  output logic [1:0]                      forward_b,
  output logic [NUM_REGS-1:0]             busy_vec,
  output logic [$clog2(MAX_LONG+1)-1:0]   pending_cnt,
  output logic [CNT_W-1:0]                stall_cycles,
  output logic                            sb_error
);

  localparam int unsigned PW = $clog2(MAX_LONG + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [PW-1:0]       pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] eff_busy;
  logic                load_use, sb_raw, sb_waw, sb_full;
  logic                issue, sb_set, sb_clr;

  // Hazard detection: scoreboard view with same-cycle completion bypass, then stall/issue.
  always_comb begin
    eff_busy = busy_q;
    if (lc_done) eff_busy[lc_rd] = 1'b0;

    load_use = ex_valid && ex_mem_read && (ex_rd != '0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    sb_raw   = (id_rs1_used && eff_busy[id_rs1]) || (id_rs2_used && eff_busy[id_rs2]);
    sb_waw   = id_reg_write && eff_busy[id_rd];
    // x0 is never marked busy, so busy_q[0] is always 0 and a completion on x0 never clears.
    sb_clr   = lc_done && (lc_rd != '0) && busy_q[lc_rd];
    sb_full  = id_long_op && (pend_q == PW'(MAX_LONG)) && !sb_clr;

    stall    = id_valid && !flush && (load_use || sb_raw || sb_waw || sb_full);
    issue    = id_valid && !stall && !flush;
    sb_set   = issue && id_long_op && id_reg_write && (id_rd != '0);
  end

  // Operand forwarding select, EX/MEM first, then long completion, then MEM/WB.
  always_comb begin
    forward_a = 2'b00;
    if (id_rs1_used && (id_rs1 != '0)) begin
      if (mem_reg_write && (mem_rd == id_rs1))     forward_a = 2'b10;
      else if (lc_done && (lc_rd == id_rs1))       forward_a = 2'b11;
      else if (wb_reg_write && (wb_rd == id_rs1))  forward_a = 2'b01;
    end
    forward_b = 2'b00;
    if (id_rs2_used && (id_rs2 != '0)) begin
      if (mem_reg_write && (mem_rd == id_rs2))     forward_b = 2'b10;
      else if (lc_done && (lc_rd == id_rs2))       forward_b = 2'b11;
      else if (wb_reg_write && (wb_rd == id_rs2))  forward_b = 2'b01;
    end
  end

  // Next-state for scoreboard, pending count, error flag and stall counter.
  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    // Clear first so a same-register set overrides it; count moves only when exactly one fires.
    if (sb_clr) busy_d[lc_rd] = 1'b0;
    if (sb_set) busy_d[id_rd] = 1'b1;
    if (sb_set && !sb_clr)      pend_d = pend_q + 1'b1;
    else if (sb_clr && !sb_set) pend_d = pend_q - 1'b1;
    if (lc_done && (lc_rd != '0) && !busy_q[lc_rd]) err_d = 1'b1;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec     = busy_q;
  assign pending_cnt  = pend_q;
  assign stall_cycles = cnt_q;
  assign sb_error     = err_q;

endmodule
